neuron_stage_collector: RTL and testbench
=========================================

# neuron_stage_collector

Output-side collector for the neuronStage datapath. It captures the serial `dataOut_0` sample stream into 32-word frames using a two-bank ping-pong buffer, then presents each completed frame to a downstream consumer as a ready/valid word stream with frame-boundary markers. It is the hardware counterpart of the stimulus side that feeds neuronStage: it turns the stage's per-cycle output stream back into addressable vectors, one entry per tap/neuron, for the next layer or a host readout.

## Interface
Parameters:
- `WIDTH`, 32: sample width in bits; carries a float_24_8 value as a raw bus.
- `DEPTH`, 32: words per frame; must be a power of two, 2..256.
- `FCNT_W`, 16: width of the completed-frame counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  input sample strobe, typically driven from neuronStage output timing.
- `in_data`  in  WIDTH  input sample.
- `in_ready`  out  1  high when the current write bank can accept a sample.
- `out_valid`  out  1  a completed frame word is presented.
- `out_ready`  in  1  consumer accepts the presented word.
- `out_data`  out  WIDTH  frame word.
- `out_index`  out  log2(DEPTH)  word position within the frame, 0..DEPTH-1.
- `out_last`  out  1  high on word DEPTH-1 of a frame.
- `frame_count`  out  FCNT_W  number of frames completed by the writer; wraps modulo 2^FCNT_W.
- `overflow`  out  1  sticky flag: a sample was dropped.

## Operation
- State:
  - two banks of DEPTH×WIDTH storage;
  - `bank_full[1:0]`;
  - `wr_bank`, `wr_idx`;
  - `rd_bank`, `rd_idx`;
  - `frame_count`;
  - `overflow`.
- Reset (asynchronous):
  - `bank_full`, `wr_bank`, `wr_idx`, `rd_bank`, `rd_idx`, `frame_count` and `overflow` are cleared to 0.
  - Bank contents are not cleared.
  - Resulting outputs: `in_ready`=1, `out_valid`=0, `out_last`=0, `out_index`=0, `overflow`=0, `frame_count`=0.
  - `out_data` is don't-care while `out_valid`=0.
- Write side:
  - `in_ready` = !`bank_full[wr_bank]`.
  - Accept when `in_valid` && `in_ready`. The accepted sample is stored at `bank[wr_bank][wr_idx]` and `wr_idx` increments.
  - On accepting word DEPTH-1:
    - set `bank_full[wr_bank]`;
    - toggle `wr_bank`;
    - set `wr_idx` to 0;
    - increment `frame_count`.
- Drop:
  - When `in_valid` && !`in_ready`, the sample is discarded, `overflow` is set, and no pointer moves.
  - `overflow` is cleared only by reset.
- Read side:
  - `out_valid` = `bank_full[rd_bank]`.
  - `out_data` = `bank[rd_bank][rd_idx]`.
  - `out_index` = `rd_idx`.
  - `out_last` = `out_valid` && (`rd_idx` == DEPTH-1).
  - On `out_valid` && `out_ready`, `rd_idx` increments.
  - On the last word: clear `bank_full[rd_bank]`, toggle `rd_bank`, and set `rd_idx` to 0.
- Ordering: frames are read in the order they were completed, and words within a frame are read in write order.
- Simultaneous events:
  - A set and a clear of different `bank_full` bits in the same cycle both take effect.
  - The same bank cannot be both written and read.
- The `in_ready` used for the accept/drop decision comes from registered `bank_full`. If a sample arrives while both banks are full, it is dropped even if the reader frees a bank in that same cycle.

## Timing
- Write latency:
  - A sample accepted at edge N is readable by edge N+1 at the earliest.
  - When word DEPTH-1 is accepted at edge N, `out_valid` rises in the cycle after edge N, provided `rd_bank` points at that bank.
- Throughput:
  - One sample accepted per cycle and one word read per cycle, concurrently.
  - A sustained input at 1 word/cycle never drops when the consumer holds `out_ready`=1 throughout.
- `in_ready` falls in the cycle after the edge that fills the second bank. It rises in the cycle after the edge that reads the last word of a frame.
- Handshake rule: while `out_valid`=1 and `out_ready`=0, `out_data`, `out_index` and `out_last` remain stable.
- Back-to-back frames: if the next bank is already full when the last word of a frame is read, `out_valid` stays high with no bubble, and `out_index` wraps from DEPTH-1 to 0.
- Reset mid-operation: all pointers and flags return to their reset values immediately, and the partially written or partially read frames are lost.
- Only the rising edge of `clk` updates state; outputs depend only on registered state and memory contents.

## Test plan
All scenarios use default parameters.
- **Single frame:** reset, then drive `in_data`=0..31 on consecutive cycles with `out_ready`=1.
  - `out_valid` rises one cycle after the 32nd write.
  - 32 words are read with `out_data`=0..31 and `out_index`=0..31; `out_last` is high only at index 31.
  - `frame_count`=1, `overflow`=0.
- **Overflow:** `out_ready`=0 throughout, drive 65 samples with `in_data`=0x100+k.
  - `in_ready` goes low after sample 64.
  - Sample 65 is dropped and `overflow`=1.
  - Then raise `out_ready`: frames read are 0x100..0x11F followed by 0x120..0x13F.
- **Streaming:** drive 4 frames continuously with `out_ready`=1.
  - `in_ready` is never 0 and `overflow` stays 0.
  - `frame_count`=4.
  - The output contains 128 words in order with no gaps between frames 1..4 beyond the initial fill.
- **Backpressure:** toggle `out_ready` as 1,0,0,1 repeating while a full frame is pending.
  - Each word holds stable while `out_ready`=0.
  - Indices 0..31 appear exactly once each.
- **Simultaneous free and arrival:** both banks full; in the same cycle the last word is read (`out_ready`=1) and `in_valid`=1.
  - That sample is dropped and `overflow`=1.
  - The next cycle `in_ready`=1 and the following sample is accepted into `wr_idx` 0.
- **Reset mid-frame:** assert `reset` asynchronously after 10 writes and 5 reads.
  - Outputs return immediately to their reset values.
  - A new 32-word frame afterwards reads back correctly with `frame_count`=1.

Source files
------------

// File: rtl/neuron_stage_collector.sv
// neuron_stage_collector
//
// Collects the serial dataOut_0 sample stream of neuronStage into
// DEPTH-word frames. Storage is two banks used as a ping-pong pair. While
// one bank is being filled, the other bank can hand its completed frame to
// a downstream consumer, one word per cycle.
//
// Ports:
//   clk          single clock; all state changes on the rising edge
//   reset        asynchronous, active-high reset
//   in_valid     input sample strobe
//   in_data      input sample (raw float_24_8 bus)
//   in_ready     current write bank can accept a sample
//   out_valid    a completed frame word is presented
//   out_ready    consumer accepts the presented word
//   out_data     presented frame word
//   out_index    word position within the frame, 0..DEPTH-1
//   out_last     presented word is word DEPTH-1 of its frame
//   frame_count  frames completed by the writer (wraps)
//   overflow     sticky: a sample was dropped since reset
//
// Handshake semantics (both sides): a transfer happens on a rising edge
// where valid and ready are both 1. A source holds its payload stable while
// valid=1 and ready=0. This block's ready/valid outputs come only from
// registered state, so neither depends combinationally on the other side.
//
// DEPTH must be a power of two (2..256). The frame index pointers then wrap
// naturally, and {bank, index} addresses the storage array directly.

module neuron_stage_collector #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 32,
    parameter int FCNT_W = 16,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  in_data,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic [IDX_W-1:0]  out_index,
    output logic              out_last,
    output logic [FCNT_W-1:0] frame_count,
    output logic              overflow
);

    // Both banks live in one array; the bank select is the top address bit.
    logic [WIDTH-1:0]  mem [0:2*DEPTH-1];

    logic [1:0]        bankFull;
    logic [1:0]        bankFullNext;
    logic              wrBank;
    logic [IDX_W-1:0]  wrIdx;
    logic              rdBank;
    logic [IDX_W-1:0]  rdIdx;
    logic [FCNT_W-1:0] frameCount;
    logic              overflowReg;

    logic              inReady;
    logic              outValid;
    logic              wrFire;
    logic              wrLast;
    logic              rdFire;
    logic              rdLast;

    // A bank being written is never full, and a bank being read is always
    // full. So the two pointers can never address the same bank in one
    // cycle.
    assign inReady  = !bankFull[wrBank];
    assign outValid = bankFull[rdBank];

    assign wrFire = in_valid && inReady;
    assign wrLast = wrFire && (wrIdx == IDX_W'(DEPTH - 1));
    assign rdFire = outValid && out_ready;
    assign rdLast = rdFire && (rdIdx == IDX_W'(DEPTH - 1));

    // wrLast only targets an empty bank, and rdLast only targets a full one.
    // When both happen in one cycle they hit different bits, and both
    // updates take effect. A bank freed this cycle is not visible to
    // inReady until the next cycle, so a sample arriving then is dropped.
    always_comb begin
        bankFullNext = bankFull;
        if (rdLast) begin
            bankFullNext[rdBank] = 1'b0;
        end
        if (wrLast) begin
            bankFullNext[wrBank] = 1'b1;
        end
    end

    // Storage has no reset; its contents are only visible once a bank is
    // marked full.
    always_ff @(posedge clk) begin
        if (wrFire) begin
            mem[{wrBank, wrIdx}] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bankFull    <= 2'b00;
            wrBank      <= 1'b0;
            wrIdx       <= '0;
            rdBank      <= 1'b0;
            rdIdx       <= '0;
            frameCount  <= '0;
            overflowReg <= 1'b0;
        end else begin
            bankFull <= bankFullNext;

            if (wrFire) begin
                if (wrLast) begin
                    wrBank     <= ~wrBank;
                    wrIdx      <= '0;
                    frameCount <= frameCount + 1'b1;
                end else begin
                    wrIdx <= wrIdx + 1'b1;
                end
            end

            if (in_valid && !inReady) begin
                overflowReg <= 1'b1;
            end

            if (rdFire) begin
                if (rdLast) begin
                    rdBank <= ~rdBank;
                    rdIdx  <= '0;
                end else begin
                    rdIdx <= rdIdx + 1'b1;
                end
            end
        end
    end

    assign in_ready    = inReady;
    assign out_valid   = outValid;
    assign out_data    = mem[{rdBank, rdIdx}];
    assign out_index   = rdIdx;
    assign out_last    = outValid && (rdIdx == IDX_W'(DEPTH - 1));
    assign frame_count = frameCount;
    assign overflow    = overflowReg;

endmodule

// File: tb/tb_neuron_stage_collector.sv
module tb_neuron_stage_collector;

    localparam int WIDTH  = 32;
    localparam int DEPTH  = 32;
    localparam int FCNT_W = 16;
    localparam int IDX_W  = 5;

    // ---------------- clock / reset ----------------
    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic [WIDTH-1:0]  in_data = '0;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [WIDTH-1:0]  out_data;
    logic [IDX_W-1:0]  out_index;
    logic              out_last;
    logic [FCNT_W-1:0] frame_count;
    logic              overflow;

    always #5 clk = ~clk;

    neuron_stage_collector #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .FCNT_W(FCNT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_index(out_index), .out_last(out_last),
        .frame_count(frame_count), .overflow(overflow)
    );

    // ---------------- scoreboard / reference model ----------------
    // exp_q holds the words of completed, not yet consumed frames, oldest
    // first. part_q holds the frame currently being collected.
    logic [WIDTH-1:0]  exp_q[$];
    logic [WIDTH-1:0]  part_q[$];
    logic [FCNT_W-1:0] m_fc;
    bit                m_ovf;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hs_count, hs_first, hs_last;

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Frames held = completed frames not yet fully read. The writer has room
    // only while fewer than two frames are held.
    function automatic int m_frames();
        return (exp_q.size() + DEPTH - 1) / DEPTH;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        part_q.delete();
        m_fc  = '0;
        m_ovf = 1'b0;
    endtask

    // ---------------- driver ----------------
    // Apply inputs for one cycle, check outputs against the model, advance
    // the clock and the model.
    task automatic step(input bit v, input logic [WIDTH-1:0] d, input bit r);
        bit e_rdy, e_val;
        int e_idx;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        e_rdy = (m_frames() < 2);
        e_val = (exp_q.size() > 0);
        e_idx = (DEPTH - (exp_q.size() % DEPTH)) % DEPTH;
        chk("in_ready", in_ready, e_rdy);
        chk("out_valid", out_valid, e_val);
        chk("frame_count", frame_count, m_fc);
        chk("overflow", overflow, m_ovf);
        if (e_val) begin
            chk("out_data", out_data, exp_q[0]);
            chk("out_index", out_index, e_idx);
            chk("out_last", out_last, (e_idx == DEPTH - 1));
        end else begin
            chk("out_last_idle", out_last, 1'b0);
        end
        if (out_valid && r) begin
            if (hs_count == 0) hs_first = cyc;
            hs_last = cyc;
            hs_count++;
        end
        @(posedge clk);
        if (v && e_rdy) begin
            part_q.push_back(d);
            if (part_q.size() == DEPTH) begin
                foreach (part_q[i]) exp_q.push_back(part_q[i]);
                part_q.delete();
                m_fc = m_fc + 1'b1;
            end
        end else if (v) begin
            m_ovf = 1'b1;
        end
        if (e_val && r) void'(exp_q.pop_front());
        cyc++;
        #1;
    endtask

    // Asserted at a point away from the clock edge; outputs must clear
    // without any edge.
    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        reset = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_out_index", out_index, '0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_frame_count", frame_count, '0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        hs_count = 0;
    endtask

    task automatic idle(input int n, input bit r);
        for (int i = 0; i < n; i++) step(1'b0, '0, r);
    endtask

    // ---------------- table-driven phases ----------------
    typedef struct {
        int          cycles;
        bit          v;
        bit          r;
        logic [15:0] exp_fc;
        bit          exp_ovf;
        bit          exp_rdy;
        bit          exp_val;
    } phase_t;

    phase_t ph [5];

    initial begin
        int k;
        logic [WIDTH-1:0] d;

        // Phases run from reset; offered data is 0x100 + k.
        ph[0] = '{64, 1'b1, 1'b0, 16'd2, 1'b0, 1'b0, 1'b1}; // fill both banks
        ph[1] = '{ 1, 1'b1, 1'b0, 16'd2, 1'b1, 1'b0, 1'b1}; // 65th sample dropped
        ph[2] = '{32, 1'b0, 1'b1, 16'd2, 1'b1, 1'b1, 1'b1}; // drain frame 0
        ph[3] = '{32, 1'b1, 1'b1, 16'd3, 1'b1, 1'b1, 1'b1}; // read 1, write 3
        ph[4] = '{40, 1'b0, 1'b1, 16'd3, 1'b1, 1'b1, 1'b0}; // drain all

        model_reset();
        hs_count = 0;
        @(posedge clk);
        #1;
        do_reset();

        // Table phases (covers the overflow scenario).
        k = 0;
        foreach (ph[p]) begin
            for (int c = 0; c < ph[p].cycles; c++) begin
                step(ph[p].v, WIDTH'(32'h100 + k), ph[p].r);
                if (ph[p].v) k++;
            end
            chk($sformatf("ph%0d_fc", p), frame_count, ph[p].exp_fc);
            chk($sformatf("ph%0d_ovf", p), overflow, ph[p].exp_ovf);
            chk($sformatf("ph%0d_in_ready", p), in_ready, ph[p].exp_rdy);
            chk($sformatf("ph%0d_out_valid", p), out_valid, ph[p].exp_val);
        end

        // Single frame 0..31 with out_ready held high.
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1'b1, WIDTH'(i), 1'b1);
        chk("single_valid_rise", out_valid, 1'b1);
        idle(DEPTH + 2, 1'b1);
        chk("single_words", hs_count, DEPTH);
        chk("single_fc", frame_count, 1);

        // Streaming: 4 frames back to back, reads with no gaps.
        do_reset();
        for (int i = 0; i < 4 * DEPTH; i++) step(1'b1, $urandom, 1'b1);
        idle(DEPTH + 2, 1'b1);
        chk("stream_words", hs_count, 4 * DEPTH);
        chk("stream_span", hs_last - hs_first + 1, 4 * DEPTH);
        chk("stream_fc", frame_count, 4);
        chk("stream_ovf", overflow, 1'b0);

        // Backpressure 1,0,0,1 on a pending frame.
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1'b1, $urandom, 1'b0);
        for (int i = 0; i < 4 * DEPTH + 4; i++) step(1'b0, '0, (i % 4 == 0) || (i % 4 == 3));
        chk("bp_words", hs_count, DEPTH);

        // Simultaneous free of a bank and arrival of a sample.
        do_reset();
        for (int i = 0; i < 2 * DEPTH; i++) step(1'b1, WIDTH'(i), 1'b0);
        idle(DEPTH - 1, 1'b1);
        step(1'b1, 32'hdead_0001, 1'b1);
        chk("simul_ovf", overflow, 1'b1);
        chk("simul_in_ready", in_ready, 1'b1);
        for (int i = 0; i < DEPTH; i++) step(1'b1, WIDTH'(32'h5000 + i), 1'b1);
        idle(2 * DEPTH + 2, 1'b1);
        chk("simul_fc", frame_count, 3);

        // Reset after 10 writes and 5 reads of the following frame.
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1'b1, $urandom, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, $urandom, (i < 5));
        in_valid = 1'b0;
        out_ready = 1'b0;
        #2;
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1'b1, WIDTH'(32'h7700 + i), 1'b1);
        idle(DEPTH + 2, 1'b1);
        chk("rstmid_fc", frame_count, 1);
        chk("rstmid_words", hs_count, DEPTH);

        // Randomized traffic against the model.
        do_reset();
        for (int blk = 0; blk < 6; blk++) begin
            int pv, pr;
            pv = $urandom_range(30, 100);
            pr = $urandom_range(20, 100);
            for (int i = 0; i < 300; i++) begin
                d = $urandom;
                step($urandom_range(0, 99) < pv, d, $urandom_range(0, 99) < pr);
            end
        end
        idle(2 * DEPTH + 2, 1'b1);
        chk("rand_drained", out_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
